// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial to a comparator and resolves target MSB-first.
// Latency: done pulses k+1 cycles after start for a k-probe search (k <= WIDTH); start is ignored unless idle.
module sar_search_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_equal,
  input  logic             is_great,
  input  logic             is_less,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hit,
  output logic             err,
  output logic [CNTW-1:0]  probes
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP = IDXW'(WIDTH - 1);
  localparam logic [IDXW-1:0]  IDX_ONE = IDXW'(1);
  localparam logic [WIDTH-1:0] BIT0    = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB     = BIT0 << (WIDTH - 1);
  localparam logic [CNTW-1:0]  CNT_ONE = CNTW'(1);

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  trial_q, trial_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [CNTW-1:0]   probes_q, probes_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hit_q, hit_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  acc_n;
  logic              flags_ok;

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    probes_d = probes_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hit_d    = hit_q;
    err_d    = err_q;
    acc_n    = acc_q;
    flags_ok = $onehot({is_equal, is_great, is_less});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          idx_d    = IDX_TOP;
          trial_d  = MSB;
          hit_d    = 1'b0;
          err_d    = 1'b0;
          probes_d = '0;
          busy_d   = 1'b1;
          state_d  = S_PROBE;
        end
      end
      S_PROBE: begin
        probes_d = probes_q + CNT_ONE;
        // Flags are combinational against the registered trial, so they apply to this cycle's probe.
        if (!flags_ok) begin
          err_d    = 1'b1;
          result_d = acc_q;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_FIN;
        end else if (is_equal) begin
          hit_d    = 1'b1;
          result_d = trial_q;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_FIN;
        end else begin
          acc_n = is_great ? trial_q : acc_q;
          acc_d = acc_n;
          if (idx_q == '0) begin
            result_d = acc_n;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_FIN;
          end else begin
            idx_d   = idx_q - IDX_ONE;
            trial_d = acc_n | (BIT0 << (idx_q - IDX_ONE));
          end
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      trial_q  <= '0;
      result_q <= '0;
      acc_q    <= '0;
      idx_q    <= IDX_TOP;
      probes_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      probes_q <= probes_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hit_q    <= hit_d;
      err_q    <= err_d;
    end
  end

  assign trial  = trial_q;
  assign result = result_q;
  assign probes = probes_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign hit    = hit_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Scoreboard bench for sar_search_ctrl with a behavioural comparator and optional flag corruption.
module tb_sar_search_ctrl;
  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          is_equal, is_great, is_less;
  logic [W-1:0]  trial, result;
  logic          busy, done, hit, err;
  logic [CW-1:0] probes;
  logic [W-1:0]  target;

  int       fault_kind = 0;
  int       fault_at   = 0;
  logic [2:0] multi_pat = 3'b111;

  int cyc  = 0;
  int pcnt = 0;
  int checks = 0;
  int errors = 0;
  logic rst_q = 1'b0;

  typedef struct {
    logic [W-1:0] tgt;
    logic [W-1:0] result;
    logic         hit;
    logic         err;
    int           probes;
    int           scyc;
  } exp_t;

  exp_t sb[$];
  int   rd = 0;
  logic [W-1:0] last_result = '0;

  sar_search_ctrl #(.WIDTH(W), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .is_equal(is_equal), .is_great(is_great), .is_less(is_less),
    .trial(trial), .busy(busy), .done(done), .result(result),
    .hit(hit), .err(err), .probes(probes)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
    if (!busy) pcnt <= 0;
    else       pcnt <= pcnt + 1;
  end

  // Behavioural comparator; optionally corrupted on one chosen probe.
  always_comb begin
    is_equal = (target == trial);
    is_great = (target > trial);
    is_less  = (target < trial);
    if (fault_kind != 0 && busy && pcnt == fault_at - 1)
      {is_equal, is_great, is_less} = (fault_kind == 1) ? 3'b000 : multi_pat;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ctz(input logic [W-1:0] t);
    for (int i = 0; i < W; i++) if (t[i]) return i;
    return W;
  endfunction

  function automatic logic [W-1:0] top_bits(input logic [W-1:0] t, input int n);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[W-1-i] = 1'b1;
    return t & m;
  endfunction

  // Probe j (1-based) keeps the target's top j-1 bits and tries bit W-j.
  function automatic logic [W-1:0] model_trial(input logic [W-1:0] t, input int j);
    logic [W-1:0] b;
    b = '0;
    b[W-j] = 1'b1;
    return top_bits(t, j - 1) | b;
  endfunction

  function automatic int nat_probes(input logic [W-1:0] t);
    return (t == '0) ? W : W - ctz(t);
  endfunction

  // Monitor: compares whatever the DUT presents against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      rd = sb.size();
      last_result = '0;
      if (rst_q) begin
        check("rst_trial",  32'(trial),  0);
        check("rst_result", 32'(result), 0);
        check("rst_probes", 32'(probes), 0);
        check("rst_busy",   32'(busy),   0);
        check("rst_done",   32'(done),   0);
        check("rst_hit",    32'(hit),    0);
        check("rst_err",    32'(err),    0);
      end
    end else begin
      if (rd < sb.size()) begin
        if (busy && pcnt < W)
          check("trial_seq", 32'(trial), 32'(model_trial(sb[rd].tgt, pcnt + 1)));
        if (done) begin
          check("result",  32'(result), 32'(sb[rd].result));
          check("hit",     32'(hit),    32'(sb[rd].hit));
          check("err",     32'(err),    32'(sb[rd].err));
          check("probes",  32'(probes), 32'(sb[rd].probes));
          check("latency", 32'(cyc - sb[rd].scyc), 32'(sb[rd].probes));
          check("busy_at_done", 32'(busy), 0);
          last_result = sb[rd].result;
          rd++;
        end
      end else begin
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
      end
      check("result_hold", 32'(result), 32'(last_result));
    end
  end

  task automatic run(input logic [W-1:0] tgt, input int fk, input int fat,
                     input bit ign_fin, input int rst_at);
    exp_t e;
    int   nat;
    bit   seen;
    @(negedge clk);
    target     = tgt;
    fault_kind = fk;
    fault_at   = fat;
    multi_pat  = 3'b011 + 3'($urandom_range(0, 3)) * 3'd2;
    if (multi_pat == 3'b001) multi_pat = 3'b111;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nat      = nat_probes(tgt);
    e.tgt    = tgt;
    e.scyc   = cyc;
    if (fk != 0 && fat <= nat) begin
      e.result = top_bits(tgt, fat - 1);
      e.hit    = 1'b0;
      e.err    = 1'b1;
      e.probes = fat;
    end else begin
      e.result = tgt;
      e.hit    = (tgt != '0);
      e.err    = 1'b0;
      e.probes = nat;
    end
    sb.push_back(e);
    seen = 1'b0;
    if (rst_at > 0) begin
      for (int i = 0; i < W + 4 && !seen; i++) begin
        @(negedge clk);
        if (busy && pcnt == rst_at - 1) seen = 1'b1;
      end
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      return;
    end
    for (int i = 0; i < W + 4 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
    end else if (ign_fin) begin
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] t;
    int nat, fk, fat;
    rst    = 1'b1;
    start  = 1'b0;
    target = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    run(8'hA5, 0, 0, 1'b0, 0);
    run(8'h80, 0, 0, 1'b0, 0);
    run(8'h00, 0, 0, 1'b0, 0);
    run(8'hFF, 0, 0, 1'b1, 0);
    run(8'h9C, 1, 3, 1'b0, 0);
    run(8'hA5, 0, 0, 1'b0, 4);
    run(8'hA5, 0, 0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      t = W'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: t = 8'h00;
          1: t = 8'h80;
          2: t = 8'hFF;
          default: t = 8'h01;
        endcase
      end
      nat = nat_probes(t);
      fk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      fat = int'($urandom_range(1, nat));
      run(t, fk, fat, bit'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(rd), 32'(sb.size()));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search controller: the initiator side of the magnitude comparator.
- Drives `trial` onto comparator input B. Comparator input A is wired to an external unsigned `target`.
- Uses the returned is_equal/is_great/is_less flags to resolve `target` MSB-first in at most WIDTH probe cycles.
- Sits in the lab data-path/FSM design as the control FSM wrapped around one comparator instance.

Parameters:
- WIDTH, 32: data width of trial/result; must match the comparator WIDTH.
- CNTW, 8: width of the probe counter; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to begin a search; sampled only in IDLE.
- is_equal  input  1  comparator flag: target == trial.
- is_great  input  1  comparator flag: target > trial.
- is_less  input  1  comparator flag: target < trial.
- trial  output  WIDTH  registered probe value driven to comparator B.
- busy  output  1  high in PROBE state.
- done  output  1  one-cycle pulse when a search ends.
- result  output  WIDTH  resolved value; held from done until the next start.
- hit  output  1  1 if an is_equal probe ended the search.
- err  output  1  1 if the flags were not one-hot on some probe.
- probes  output  CNTW  number of probe cycles used by the last search.

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-search):
  - state=IDLE.
  - trial, result, probes = 0.
  - busy, done, hit, err = 0.
  - Internal acc=0, idx=WIDTH-1.
- States: IDLE, PROBE, FIN.
- IDLE:
  - start=1 -> load acc=0, idx=WIDTH-1, trial=1<<(WIDTH-1).
  - Clear hit, err, probes; go to PROBE.
  - result keeps its old value until FIN.
  - start=0 -> stay in IDLE.
- PROBE (busy=1): each cycle, sample the flags against the current registered trial. The comparator is combinational, so there is zero-cycle flag latency. probes increments by 1.
  - Flags not exactly one-hot (none, or more than one set) -> err=1, result=acc, go FIN.
  - is_equal -> result=trial, hit=1, go FIN.
  - is_great -> acc=trial (keep bit idx).
  - is_less -> acc unchanged (drop bit idx).
  - After is_great or is_less:
    - idx==0 -> result=new acc, go FIN.
    - Otherwise idx-=1 and trial = new acc | (1<<(idx-1)).
  - start is ignored in PROBE.
- FIN:
  - done=1 for exactly this one cycle; busy=0; next state IDLE.
  - start in FIN is ignored; a new start is accepted only in IDLE.
  - trial holds its last value until the next start.
- Timing:
  - start sampled at edge N -> first probe in cycle N+1.
  - A search with k probes asserts done in cycle N+k+1.
  - Worst case k=WIDTH.
- Boundary conditions:
  - target=0: every probe returns is_less; ends on exhaustion with result=0, hit=0, probes=WIDTH.
  - target=2^(WIDTH-1): first probe returns equal; probes=1.
- All arithmetic is unsigned. acc and trial never exceed 2^WIDTH-1; there is no wrap-around.

Test Plan (WIDTH=8, comparator instance with A=target, B=trial):
- Target 0xA5, start pulse:
  - trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
  - done 9 cycles after start, result=0xA5, hit=1, probes=8, err=0.
- Target 0x80: trial 0x80 on the first probe -> done 2 cycles after start, result=0x80, hit=1, probes=1.
- Target 0x00:
  - trial sequence 0x80,0x40,...,0x01, all is_less.
  - result=0x00, hit=0, probes=8.
- Target 0xFF: trials 0x80,0xC0,...,0xFE,0xFF -> result=0xFF, hit=1, probes=8. Then assert start during FIN -> ignored, busy stays 0.
- Force flags to 0 (comparator bypassed) on the 3rd probe, with acc=0x80 at that point -> err=1, done pulse, result=0x80, probes=3.
- Assert rst at the 4th probe of the 0xA5 search -> next cycle IDLE with all outputs 0. A new start then gives the correct 0xA5 result.
